// File: rtl/metronome_core_if.sv
// Handshake bundle between the metronome tempo engine and its controls/display drivers.
// The BCD display outputs exist only when METRO_BCD_EN is defined.
interface metronome_core_if #(
  parameter int BPM_W  = 9,
  parameter int BEAT_W = 4
);
  logic              enable;
  logic              bpm_up;
  logic              bpm_down;
  logic [BEAT_W-1:0] beats_per_bar;
  logic              beat;
  logic              accent;
  logic              led;
  logic [BPM_W-1:0]  bpm;
  logic [BEAT_W-1:0] beat_idx;
`ifdef METRO_BCD_EN
  logic [11:0]       bpm_bcd;
  logic              bcd_valid;

  modport master (output enable, bpm_up, bpm_down, beats_per_bar,
                  input  beat, accent, led, bpm, beat_idx, bpm_bcd, bcd_valid);
  modport slave  (input  enable, bpm_up, bpm_down, beats_per_bar,
                  output beat, accent, led, bpm, beat_idx, bpm_bcd, bcd_valid);
`else
  modport master (output enable, bpm_up, bpm_down, beats_per_bar,
                  input  beat, accent, led, bpm, beat_idx);
  modport slave  (input  enable, bpm_up, bpm_down, beats_per_bar,
                  output beat, accent, led, bpm, beat_idx);
`endif
endinterface

// File: rtl/metronome_core.sv
// Phase-accumulator tempo engine: beat/accent strobes, stretched LED pulse, measure position.
// Define METRO_BCD_EN to add a sequential double-dabble bpm -> 3-digit BCD converter.
module metronome_core #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int BPM_W       = 9,
  parameter int BPM_MIN     = 30,
  parameter int BPM_MAX     = 300,
  parameter int BPM_DEFAULT = 120,
  parameter int BPM_STEP    = 1,
  parameter int BEAT_W      = 4,
  parameter int PULSE_CYC   = 5_000_000
) (
  input logic               CLOCK_50,
  input logic               RESET,
  metronome_core_if.slave   bus
);
  localparam logic [63:0]       PERIOD   = 64'(60) * 64'(CLK_HZ);
  localparam int                ACC_W    = $clog2(PERIOD + 64'(BPM_MAX));
  localparam logic [ACC_W-1:0]  PERIOD_A = ACC_W'(PERIOD);
  localparam int                PC_W     = $clog2(PULSE_CYC + 1);
  localparam int                BX_W     = BPM_W + 1;
  localparam logic [BX_W-1:0]   MAX_X    = BX_W'(BPM_MAX);
  localparam logic [BX_W-1:0]   MIN_X    = BX_W'(BPM_MIN);
  localparam logic [BX_W-1:0]   STEP_X   = BX_W'(BPM_STEP);

  typedef enum logic {ST_STOP, ST_RUN} state_t;

  state_t            state_q, state_d;
  logic              start;
  logic [ACC_W-1:0]  acc_q, sum;
  logic              tick;
  logic [BPM_W-1:0]  bpm_q, bpm_next;
  logic [BX_W-1:0]   bpm_x, bpm_inc;
  logic [BEAT_W-1:0] idx_q, idx_wrap;
  logic [BEAT_W:0]   idx_inc, bpb_eff;
  logic              beat_q, accent_q, led_q;
  logic [PC_W-1:0]   pcnt_q;

  // NOTE: registered state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) state_q <= ST_STOP;
    else       state_q <= state_d;
  end

  // NOTE: every output of a combinational block gets a default first; a missed branch would infer a latch.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    case (state_q)
      ST_STOP: if (bus.enable) begin
        state_d = ST_RUN;
        start   = 1'b1;
      end
      ST_RUN:  if (!bus.enable) state_d = ST_STOP;
      default: state_d = ST_STOP;
    endcase
  end

  always_comb begin
    sum      = acc_q + ACC_W'(bpm_q);
    tick     = (sum >= PERIOD_A);
    idx_inc  = {1'b0, idx_q} + 1'b1;
    bpb_eff  = (bus.beats_per_bar == '0) ? (BEAT_W+1)'(1) : {1'b0, bus.beats_per_bar};
    idx_wrap = (idx_inc >= bpb_eff) ? '0 : idx_inc[BEAT_W-1:0];
  end

  // Up and down in the same cycle cancel; both directions saturate at the tempo limits.
  always_comb begin
    bpm_x    = {1'b0, bpm_q};
    bpm_inc  = bpm_x + STEP_X;
    bpm_next = bpm_q;
    if (bus.bpm_up && !bus.bpm_down)
      bpm_next = (bpm_inc > MAX_X) ? BPM_W'(BPM_MAX) : bpm_inc[BPM_W-1:0];
    else if (bus.bpm_down && !bus.bpm_up)
      bpm_next = (bpm_x < MIN_X + STEP_X) ? BPM_W'(BPM_MIN) : bpm_q - BPM_W'(BPM_STEP);
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) bpm_q <= BPM_W'(BPM_DEFAULT);
    else       bpm_q <= bpm_next;
  end

  // Accumulator keeps its phase across tempo changes; only stop/start clears it.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      acc_q    <= '0;
      idx_q    <= '0;
      beat_q   <= 1'b0;
      accent_q <= 1'b0;
      led_q    <= 1'b0;
      pcnt_q   <= '0;
    end else if (!bus.enable) begin
      acc_q    <= '0;
      idx_q    <= '0;
      beat_q   <= 1'b0;
      accent_q <= 1'b0;
      led_q    <= 1'b0;
      pcnt_q   <= '0;
    end else if (start) begin
      acc_q    <= '0;
      idx_q    <= '0;
      beat_q   <= 1'b1;
      accent_q <= 1'b1;
      led_q    <= 1'b1;
      pcnt_q   <= PC_W'(PULSE_CYC);
    end else begin
      acc_q    <= tick ? (sum - PERIOD_A) : sum;
      beat_q   <= tick;
      accent_q <= tick && (idx_wrap == '0);
      if (tick) begin
        idx_q  <= idx_wrap;
        led_q  <= 1'b1;
        pcnt_q <= PC_W'(PULSE_CYC);
      end else if (pcnt_q > PC_W'(1)) begin
        pcnt_q <= pcnt_q - 1'b1;
      end else begin
        pcnt_q <= '0;
        led_q  <= 1'b0;
      end
    end
  end

  assign bus.beat     = beat_q;
  assign bus.accent   = accent_q;
  assign bus.led      = led_q;
  assign bus.bpm      = bpm_q;
  assign bus.beat_idx = idx_q;

`ifdef METRO_BCD_EN
  localparam int SC_W = $clog2(BPM_W + 1);

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  localparam logic [11:0] BCD_DEF = to_bcd(BPM_DEFAULT);

  logic [11:0]         bcd_q, work_q, adj;
  logic [BPM_W-1:0]    bin_q;
  logic [SC_W-1:0]     sh_cnt_q;
  logic                busy_q, valid_q;
  logic [12+BPM_W-1:0] shifted;

  // Add-3 on any digit >= 5 before each shift keeps the digits decimal.
  always_comb begin
    adj = work_q;
    for (int d = 0; d < 3; d++)
      if (work_q[4*d +: 4] >= 4'd5) adj[4*d +: 4] = work_q[4*d +: 4] + 4'd3;
    shifted = {adj, bin_q} << 1;
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      bcd_q    <= BCD_DEF;
      valid_q  <= 1'b1;
      busy_q   <= 1'b0;
      sh_cnt_q <= '0;
      bin_q    <= '0;
      work_q   <= '0;
    end else if (bpm_next != bpm_q) begin
      bin_q    <= bpm_next;
      work_q   <= '0;
      sh_cnt_q <= SC_W'(BPM_W);
      busy_q   <= 1'b1;
      valid_q  <= 1'b0;
    end else if (busy_q) begin
      if (sh_cnt_q != '0) begin
        work_q   <= shifted[12+BPM_W-1:BPM_W];
        bin_q    <= shifted[BPM_W-1:0];
        sh_cnt_q <= sh_cnt_q - 1'b1;
      end else begin
        bcd_q   <= work_q;
        valid_q <= 1'b1;
        busy_q  <= 1'b0;
      end
    end
  end

  assign bus.bpm_bcd   = bcd_q;
  assign bus.bcd_valid = valid_q;
`endif

endmodule
